id_regfile_nia: RTL and testbench

- Decode-stage datapath core for the 32-bit MIPS pipeline. It pairs the architectural register file with the next-instruction-address (branch/jump target) calculator.
- The instruction decoder and the branch comparator sit outside this block. They drive its control inputs and consume its outputs.
- The block contains one sequential element, the register array. Everything else is combinational.

---
 rtl/id_regfile_nia_pkg.sv | 32 +++
 rtl/id_regfile_nia_if.sv | 33 +++
 rtl/id_regfile_nia_regfile_3r1w.sv | 41 ++++
 rtl/id_regfile_nia.sv | 54 +++++
 tb/tb_id_regfile_nia.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/id_regfile_nia_pkg.sv
// Shared definitions for the decode-stage register file / next-address block.
// Holds datapath widths, the hard-wired zero register index, MIPS instruction
// field positions and the branch-offset helper.
package id_regfile_nia_pkg;

  localparam int DATA_W    = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;
  localparam int RD_PORTS  = 3;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // Instruction field bit positions
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  // Sign-extended word offset of a 16-bit branch immediate (imm << 2).
  function automatic logic [DATA_W-1:0] br_offset(input logic [15:0] imm);
    return {{(DATA_W-18){imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/id_regfile_nia_if.sv
// Decode-stage bus between the instruction decoder / writeback logic (master)
// and the register file + next-address block (slave).
//   master drives: read indices, writeback port, PC+4, instruction, jump controls
//   slave drives : three read data words and NextInstructionAddress
interface id_regfile_nia_if;
  import id_regfile_nia_pkg::*;

  logic [REG_IDX_W-1:0] RegA1, RegB1, RegC1;
  logic [DATA_W-1:0]    DataA1, DataB1, DataC1;
  logic [REG_IDX_W-1:0] WriteReg1;
  logic [DATA_W-1:0]    WriteData1;
  logic                 Write1;
  logic [DATA_W-1:0]    Instr_PC_Plus4;
  logic [DATA_W-1:0]    Instruction;
  logic                 Jump;
  logic                 JumpRegister;
  logic [DATA_W-1:0]    RegisterValue;
  logic [REG_IDX_W-1:0] Register;
  logic [DATA_W-1:0]    NextInstructionAddress;

  modport master (
    output RegA1, RegB1, RegC1, WriteReg1, WriteData1, Write1,
           Instr_PC_Plus4, Instruction, Jump, JumpRegister, RegisterValue, Register,
    input  DataA1, DataB1, DataC1, NextInstructionAddress
  );

  modport slave (
    input  RegA1, RegB1, RegC1, WriteReg1, WriteData1, Write1,
           Instr_PC_Plus4, Instruction, Jump, JumpRegister, RegisterValue, Register,
    output DataA1, DataB1, DataC1, NextInstructionAddress
  );

endinterface

// File: rtl/id_regfile_nia_regfile_3r1w.sv
// 3-read / 1-write architectural register file.
//   CLK, RESET  : clock (rising edge), async active-low clear of all registers
//   idx/data    : RD_PORTS independent combinational read ports
//   wen/widx/wdata : write port, committed on the rising edge
// r0 is hard-wired to zero. A read that hits the register being written this
// cycle returns the incoming write data (write-through bypass).
module regfile_3r1w
  import id_regfile_nia_pkg::*;
#(
  parameter int DATA_W   = id_regfile_nia_pkg::DATA_W,
  parameter int NREGS    = id_regfile_nia_pkg::NREGS,
  parameter int RD_PORTS = id_regfile_nia_pkg::RD_PORTS
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [RD_PORTS-1:0][REG_IDX_W-1:0]  idx,
  output logic [RD_PORTS-1:0][DATA_W-1:0]     data,
  input  logic                                wen,
  input  logic [REG_IDX_W-1:0]                widx,
  input  logic [DATA_W-1:0]                   wdata
);

  logic [NREGS-1:0][DATA_W-1:0] regs;

  // Effective write: r0 writes are dropped; bypass is suppressed while in
  // reset so every read port shows the cleared array.
  logic wr_act;
  assign wr_act = wen && (widx != REG_ZERO);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      regs         <= '0;
    else if (wr_act) regs[widx]   <= wdata;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    assign data[p] = (idx[p] == REG_ZERO)               ? '0    :
                     (wr_act && RESET && idx[p] == widx) ? wdata :
                                                           regs[idx[p]];
  end

endmodule

// File: rtl/id_regfile_nia.sv
// Decode-stage datapath core: register file plus next-instruction-address
// (branch / J / JR target) calculator.
//   CLK, RESET : clock (rising edge), async active-low reset
//   bus        : slave side of id_regfile_nia_if (read ports A/B/C, writeback
//                port, PC+4, instruction, jump controls, NextInstructionAddress)
// The address path is purely combinational; the caller gates it with its own
// taken/jump decision.
module id_regfile_nia
  import id_regfile_nia_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  id_regfile_nia_if.slave bus
);

  logic [RD_PORTS-1:0][REG_IDX_W-1:0] rd_idx;
  logic [RD_PORTS-1:0][DATA_W-1:0]    rd_data;

  assign rd_idx = {bus.RegC1, bus.RegB1, bus.RegA1};

  regfile_3r1w u_rf (
    .CLK   (CLK),
    .RESET (RESET),
    .idx   (rd_idx),
    .data  (rd_data),
    .wen   (bus.Write1),
    .widx  (bus.WriteReg1),
    .wdata (bus.WriteData1)
  );

  assign bus.DataA1 = rd_data[0];
  assign bus.DataB1 = rd_data[1];
  assign bus.DataC1 = rd_data[2];

  // Next instruction address. JumpRegister only matters alongside Jump.
  logic [DATA_W-1:0] nia;
  always_comb begin
    nia = bus.Instr_PC_Plus4 + br_offset(bus.Instruction[IMM_HI:IMM_LO]);
    if (bus.Jump) begin
      if (bus.JumpRegister)
        nia = bus.RegisterValue;
      else
        nia = {bus.Instr_PC_Plus4[DATA_W-1:DATA_W-4],
               bus.Instruction[TARGET_HI:TARGET_LO], 2'b00};
    end
  end
  assign bus.NextInstructionAddress = nia;

  // rs index is carried on the bus for compatibility only; opcode bits are
  // decoded elsewhere.
  logic unused_bits;
  assign unused_bits = ^{bus.Register, bus.Instruction[31:26]};

endmodule

// File: tb/tb_id_regfile_nia.sv
module tb_id_regfile_nia;
  import id_regfile_nia_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  id_regfile_nia_if bus ();

  id_regfile_nia dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Commit on the next rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    bus.RegA1 = a;
    bus.RegB1 = b;
    bus.RegC1 = c;
  endtask

  task automatic wr(input logic en, input logic [4:0] idx, input logic [31:0] d);
    bus.Write1     = en;
    bus.WriteReg1  = idx;
    bus.WriteData1 = d;
  endtask

  initial begin
    rst_n = 1'b0;
    rd(5'd0, 5'd0, 5'd0);
    wr(1'b0, 5'd0, 32'h0);
    bus.Instr_PC_Plus4 = 32'h0;
    bus.Instruction    = 32'h0;
    bus.Jump           = 1'b0;
    bus.JumpRegister   = 1'b0;
    bus.RegisterValue  = 32'h0;
    bus.Register       = 5'd0;
    #12;
    rd(5'd5, 5'd7, 5'd31);
    #1;
    chk("reset_a", bus.DataA1, 32'h0);
    chk("reset_b", bus.DataB1, 32'h0);
    chk("reset_c", bus.DataC1, 32'h0);
    chk("reset_nia", bus.NextInstructionAddress, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write r5, then async reset mid-cycle
    @(negedge clk);
    wr(1'b1, 5'd5, 32'h12345678);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(5'd5, 5'd5, 5'd5);
    #1;
    chk("r5_written", bus.DataA1, 32'h12345678);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", bus.DataA1, 32'h0);
    chk("async_rst_b", bus.DataB1, 32'h0);
    chk("async_rst_c", bus.DataC1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("r5_after_rst", bus.DataB1, 32'h0);

    // Write r7, read on all ports
    @(negedge clk);
    wr(1'b1, 5'd7, 32'hDEADBEEF);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(5'd7, 5'd7, 5'd7);
    #1;
    chk("r7_a", bus.DataA1, 32'hDEADBEEF);
    chk("r7_b", bus.DataB1, 32'hDEADBEEF);
    chk("r7_c", bus.DataC1, 32'hDEADBEEF);

    // Bypass on B and C, A reads stored r7
    @(negedge clk);
    wr(1'b1, 5'd9, 32'hA5A5A5A5);
    rd(5'd7, 5'd9, 5'd9);
    #1;
    chk("bypass_b", bus.DataB1, 32'hA5A5A5A5);
    chk("bypass_c", bus.DataC1, 32'hA5A5A5A5);
    chk("no_bypass_a", bus.DataA1, 32'hDEADBEEF);
    tick();
    wr(1'b0, 5'd9, 32'h0);
    #1;
    chk("r9_stored", bus.DataB1, 32'hA5A5A5A5);

    // r0 write discarded, including through the bypass
    @(negedge clk);
    wr(1'b1, 5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0, 5'd0);
    #1;
    chk("r0_bypass_a", bus.DataA1, 32'h0);
    chk("r0_bypass_c", bus.DataC1, 32'h0);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    chk("r0_after", bus.DataB1, 32'h0);
    rd(5'd7, 5'd9, 5'd5);
    #1;
    chk("r7_kept", bus.DataA1, 32'hDEADBEEF);

    // J target
    bus.Instr_PC_Plus4 = 32'h00400008;
    bus.Instruction    = 32'h08100010;
    bus.Jump           = 1'b1;
    bus.JumpRegister   = 1'b0;
    #1;
    chk("j_target", bus.NextInstructionAddress, 32'h00400040);
    bus.Instr_PC_Plus4 = 32'hA0000004;
    bus.Instruction    = 32'h0BFFFFFF;
    #1;
    chk("j_target_hi", bus.NextInstructionAddress, 32'hAFFFFFFC);

    // Branch targets
    bus.Jump           = 1'b0;
    bus.Instr_PC_Plus4 = 32'h00400010;
    bus.Instruction    = 32'h1000FFFC;
    #1;
    chk("br_neg", bus.NextInstructionAddress, 32'h00400000);
    bus.Instruction    = 32'h10000003;
    #1;
    chk("br_pos", bus.NextInstructionAddress, 32'h0040001C);
    bus.Instr_PC_Plus4 = 32'hFFFFFFFC;
    bus.Instruction    = 32'h10000001;
    #1;
    chk("br_wrap", bus.NextInstructionAddress, 32'h00000000);

    // JR, and JumpRegister without Jump
    bus.Instr_PC_Plus4 = 32'h00400010;
    bus.Instruction    = 32'h10000003;
    bus.RegisterValue  = 32'h0040ABCC;
    bus.Jump           = 1'b1;
    bus.JumpRegister   = 1'b1;
    #1;
    chk("jr_target", bus.NextInstructionAddress, 32'h0040ABCC);
    bus.Jump           = 1'b0;
    #1;
    chk("jr_no_jump", bus.NextInstructionAddress, 32'h0040001C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
